// File: rtl/alu_pipe.sv
// Handshaked WIDTH-bit ALU with registered result, Z/N/V flag register and iterative shift-add multiply.
// Build option ALU_SAT_EN: ADD/SUB saturate on signed overflow instead of wrapping.
//
// state | meaning
// IDLE  | single-cycle ops accepted when the output slot is free
// MUL   | shift-add multiply in progress, one partial-product step per edge
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags,
    output logic             busy
);
    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_MUL    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LLB    = 4'b1010;
    localparam logic [3:0] OP_LHB    = 4'b1011;
    localparam logic [3:0] OP_PCS    = 4'b1110;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           r_state, w_next_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_mcand, r_mplier, r_acc, w_acc_next;
    logic [WIDTH-1:0] r_result;
    logic             r_out_valid;
    logic [2:0]       r_flags;

    logic             w_accept, w_mul_start, w_mul_done, w_single;
    logic             w_wr_z, w_wr_nv;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_ovf;

    logic [WIDTH-1:0] w_sum, w_diff, w_padd;
    logic [2*WIDTH-1:0] w_rot;
    logic [SHW-1:0]   w_shamt;
    logic             w_add_ovf, w_sub_ovf;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // FSM: next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_mul_start) w_next_state = S_MUL;
            S_MUL:  if (w_mul_done)  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy     = (r_state == S_MUL);
        in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    end

    assign w_accept    = in_valid && in_ready;
    assign w_mul_start = w_accept && (opcode == OP_MUL);
    assign w_single    = w_accept && (opcode != OP_MUL);
    assign w_mul_done  = (r_state == S_MUL) && (r_cnt == '0);
    assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);

    assign w_shamt   = op2[SHW-1:0];
    assign w_sum     = op1 + op2;
    assign w_diff    = op1 - op2;
    assign w_add_ovf = (op1[MSB] == op2[MSB]) && (w_sum[MSB] != op1[MSB]);
    assign w_sub_ovf = (op1[MSB] != op2[MSB]) && (w_diff[MSB] != op1[MSB]);
    assign w_rot     = {op1, op1} >> w_shamt;

`ifdef ALU_SAT_EN
    // Overflow direction follows op1's sign in both ADD and SUB.
    logic [WIDTH-1:0] w_sat_val;
    assign w_sat_val = op1[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif

    for (genvar g = 0; g < WIDTH/4; g++) begin : g_lane
        logic [4:0] w_lsum;
        assign w_lsum = {op1[4*g+3], op1[4*g +: 4]} + {op2[4*g+3], op2[4*g +: 4]};
        assign w_padd[4*g +: 4] = (w_lsum[4] != w_lsum[3]) ? (w_lsum[4] ? 4'b1000 : 4'b0111)
                                                             : w_lsum[3:0];
    end

    always_comb begin
        w_alu_res = '1;
        w_ovf     = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_ovf = w_add_ovf;
`ifdef ALU_SAT_EN
                w_alu_res = w_add_ovf ? w_sat_val : w_sum;
`else
                w_alu_res = w_sum;
`endif
            end
            OP_SUB: begin
                w_ovf = w_sub_ovf;
`ifdef ALU_SAT_EN
                w_alu_res = w_sub_ovf ? w_sat_val : w_diff;
`else
                w_alu_res = w_diff;
`endif
            end
            OP_XOR:        w_alu_res = op1 ^ op2;
            OP_SLL:        w_alu_res = op1 << w_shamt;
            OP_SRA:        w_alu_res = $unsigned($signed(op1) >>> w_shamt);
            OP_ROR:        w_alu_res = w_rot[WIDTH-1:0];
            OP_PADDSB:     w_alu_res = w_padd;
            OP_LW, OP_SW:  w_alu_res = {op1[WIDTH-1:1], 1'b0} + {op2[WIDTH-2:0], 1'b0};
            OP_LLB:        w_alu_res = {op1[WIDTH-1:WIDTH/2], op2[WIDTH/2-1:0]};
            OP_LHB:        w_alu_res = {op2[WIDTH/2-1:0], op1[WIDTH/2-1:0]};
            OP_PCS:        w_alu_res = op1 + WIDTH'(2);
            default:       w_alu_res = '1;
        endcase
    end

    always_comb begin
        w_wr_nv = (opcode == OP_ADD) || (opcode == OP_SUB);
        w_wr_z  = w_wr_nv || (opcode == OP_XOR) || (opcode == OP_SLL)
                  || (opcode == OP_SRA) || (opcode == OP_ROR);
    end

    // Multiplier datapath: down-counter terminal count marks the final step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (w_mul_start) begin
            r_cnt    <= CW'(WIDTH - 1);
            r_mcand  <= op1;
            r_mplier <= op2;
            r_acc    <= '0;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_flags     <= 3'b000;
        end else if (w_single) begin
            r_result    <= w_alu_res;
            r_out_valid <= 1'b1;
            if (w_wr_z) r_flags[0] <= (w_alu_res == '0);
            if (w_wr_nv) begin
                r_flags[1] <= w_alu_res[MSB];
                r_flags[2] <= w_ovf;
            end
        end else if (w_mul_done) begin
            r_result    <= w_acc_next;
            r_out_valid <= 1'b1;
            r_flags[0]  <= (w_acc_next == '0);
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign result    = r_result;
    assign out_valid = r_out_valid;
    assign flags     = r_flags;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=16: expected {flags,result} queued at accept, compared on consume.
module tb_alu_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [15:0] op1, op2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [2:0]  flags;
    logic        busy;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [18:0] q_exp[$];
    logic [18:0] e_head;
    logic [2:0]  m_flags;
    int          nb, lat;

    alu_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .op1(op1), .op2(op2), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: returns {flags, result}.
    function automatic logic [18:0] model(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [2:0] f_in);
        int          sa, sbv, s, la, lb, ls, n;
        logic [31:0] r;
        logic [2:0]  f;
        logic        ovf;
        f = f_in;
        n = int'(b[3:0]);
        r = 32'hFFFF;
        case (op)
            4'd0, 4'd1: begin
                sa = $signed(a); sbv = $signed(b);
                s = (op == 4'd0) ? sa + sbv : sa - sbv;
                ovf = (s > 32767) || (s < -32768);
`ifdef ALU_SAT_EN
                if (ovf) s = (s > 0) ? 32767 : -32768;
`endif
                r = s;
                f = {ovf, r[15], r[15:0] == 16'h0};
            end
            4'd2: r = {16'h0, a ^ b};
            4'd3: r = {16'h0, a} * {16'h0, b};
            4'd4: r = {16'h0, a} << n;
            4'd5: begin sa = $signed(a); r = sa >>> n; end
            4'd6: r = ({16'h0, a} >> n) | ({16'h0, a} << (16 - n));
            4'd7: begin
                r = 0;
                for (int i = 0; i < 4; i++) begin
                    la = $signed(a[4*i +: 4]); lb = $signed(b[4*i +: 4]);
                    ls = la + lb;
                    if (ls > 7) ls = 7;
                    if (ls < -8) ls = -8;
                    r = r | ((ls & 15) << (4*i));
                end
            end
            4'd8, 4'd9: r = ({16'h0, a} & 32'hFFFE) + {16'h0, b} * 2;
            4'd10: r = {16'h0, a[15:8], b[7:0]};
            4'd11: r = {16'h0, b[7:0], a[7:0]};
            4'd14: r = {16'h0, a} + 2;
            default: r = 32'hFFFF;
        endcase
        if (op inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6}) f[0] = (r[15:0] == 16'h0);
        return {f, r[15:0]};
    endfunction

    // Scoreboard consumer: a result seen with out_ready high at negedge is taken on the next edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q_exp.size() == 0) check("sb_underflow", 32'd1, 32'd0);
            else begin
                e_head = q_exp.pop_front();
                check("sb_result", {16'h0, result}, {16'h0, e_head[15:0]});
                check("sb_flags", {29'h0, flags}, {29'h0, e_head[18:16]});
            end
        end
    end

    // Called just after a posedge; returns 1 ns after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [18:0] m;
        opcode = op; op1 = a; op2 = b; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                m = model(op, a, b, m_flags);
                m_flags = m[18:16];
                q_exp.push_back(m);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
        end
        check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q_exp.size() > 0; i++) @(posedge clk);
        #1;
        check("drain_empty", q_exp.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  t_op[14];
        logic [15:0] t_a[14], t_b[14];
        t_op = '{4'd7, 4'd7, 4'd5, 4'd6, 4'd4, 4'd4, 4'd2, 4'd8, 4'd9, 4'd10, 4'd11, 4'd14, 4'd12, 4'd1};
        t_a  = '{16'h7777, 16'h8888, 16'h8000, 16'h0001, 16'h1234, 16'h1234, 16'hAAAA,
                 16'h1235, 16'hFFFF, 16'h1234, 16'h1234, 16'hFFFF, 16'h0000, 16'h8000};
        t_b  = '{16'h1111, 16'hF0F0, 16'h000F, 16'h0001, 16'h0000, 16'h0004, 16'hAAAA,
                 16'h0010, 16'h8001, 16'h5678, 16'h5678, 16'h0000, 16'h0000, 16'h0001};

        rst = 1'b1; in_valid = 1'b0; opcode = 4'd0; op1 = '0; op2 = '0; out_ready = 1'b1;
        m_flags = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", {16'h0, result}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'd0);
        check("rst_flags", {29'h0, flags}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_in_ready", {31'h0, in_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Overflowing ADD, result visible one edge after accept.
        issue(4'd0, 16'h7FFF, 16'h0001);
        check("add_lat_valid", {31'h0, out_valid}, 32'd1);
`ifdef ALU_SAT_EN
        check("add_ovf_result", {16'h0, result}, 32'h7FFF);
        check("add_ovf_flags", {29'h0, flags}, 32'h4);
`else
        check("add_ovf_result", {16'h0, result}, 32'h8000);
        check("add_ovf_flags", {29'h0, flags}, 32'h6);
`endif

        // Multiply: 16 busy cycles, result on the 16th edge after accept.
        issue(4'd3, 16'h0003, 16'h0005);
        nb = 0; lat = -1;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            if (busy && !in_ready) nb++;
            if (out_valid) begin
                lat = k;
                check("mul_result", {16'h0, result}, 32'h000F);
            end
            @(posedge clk); #1;
        end
        check("mul_busy_cycles", nb, 16);
        check("mul_latency", lat, 16);
        issue(4'd3, 16'h0100, 16'h0100);
        drain();
        check("mul_zero_z", {31'h0, flags[0]}, 32'd1);

        // Table of single-cycle ops, back to back.
        for (int i = 0; i < 14; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            if (i == 0) check("paddsb_pos_sat", {16'h0, result}, 32'h7777);
            if (i == 1) check("paddsb_neg_sat", {16'h0, result}, 32'h8888);
            if (i == 2) check("sra_15", {16'h0, result}, 32'hFFFF);
            if (i == 3) check("ror_1", {16'h0, result}, 32'h8000);
            if (i == 4) check("sll_0", {16'h0, result}, 32'h1234);
        end
        drain();

        // Backpressure: XOR result held while an ADD waits.
        out_ready = 1'b0;
        issue(4'd2, 16'h00FF, 16'h0F0F);
        opcode = 4'd0; op1 = 16'h0001; op2 = 16'h0002; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("bp_in_ready", {31'h0, in_ready}, 32'd0);
            check("bp_result", {16'h0, result}, 32'h0FF0);
            check("bp_flags", {29'h0, flags}, {29'h0, m_flags});
        end
        out_ready = 1'b1;
        issue(4'd0, 16'h0001, 16'h0002);
        check("bp_valid_kept", {31'h0, out_valid}, 32'd1);
        check("bp_new_result", {16'h0, result}, 32'h0003);
        drain();

        // Flag isolation.
        issue(4'd1, 16'h0005, 16'h0005);
        check("sub_zero_flags", {29'h0, flags}, 32'h1);
        issue(4'd10, 16'hABCD, 16'h1234);
        check("llb_flags_held", {29'h0, flags}, 32'h1);
        issue(4'd2, 16'h0001, 16'h0000);
        check("xor_flags", {29'h0, flags}, 32'h0);
        drain();

        // Reset in the middle of a multiply.
        issue(4'd1, 16'h8000, 16'h0001);
        drain();
        issue(4'd3, 16'h0003, 16'h0005);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        q_exp.delete();
        m_flags = 3'b000;
        @(posedge clk); #1;
        check("mrst_out_valid", {31'h0, out_valid}, 32'd0);
        check("mrst_busy", {31'h0, busy}, 32'd0);
        check("mrst_flags", {29'h0, flags}, 32'd0);
        check("mrst_in_ready", {31'h0, in_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        issue(4'd0, 16'h0002, 16'h0003);
        check("post_rst_add", {16'h0, result}, 32'h0005);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
